conv_mac_accumulator: RTL and testbench

//  Streaming multiply-accumulate stage directly upstream of the ReLU activation stage.

---
 rtl/sr_fixed_pkg.sv | 18 +
 rtl/sat_clamp.sv | 26 ++
 rtl/conv_mac_accumulator.sv | 114 +++++++++++
 tb/tb_conv_mac_accumulator.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sr_fixed_pkg.sv
// Shared fixed-point definitions for the convolution datapath stages:
// default widths, the MAC window state encoding and ACC_W saturation limits.
package sr_fixed_pkg;

    localparam int DATA_W_DEF   = 16;
    localparam int WEIGHT_W_DEF = 16;
    localparam int ACC_W_DEF    = 32;

    typedef enum logic [1:0] {
        ST_ACCUM = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HOLD  = 2'd2
    } mac_state_t;

    localparam logic signed [ACC_W_DEF-1:0] SAT_MAX = {1'b0, {(ACC_W_DEF-1){1'b1}}};
    localparam logic signed [ACC_W_DEF-1:0] SAT_MIN = {1'b1, {(ACC_W_DEF-1){1'b0}}};

endpackage

// File: rtl/sat_clamp.sv
// Combinational signed saturation from IN_W down to OUT_W bits.
// Out-of-range values clamp to the most positive / most negative OUT_W value.
module sat_clamp #(
    parameter int IN_W  = 40,
    parameter int OUT_W = 32
) (
    input  logic signed [IN_W-1:0]  value,
    output logic signed [OUT_W-1:0] clamped
);

    // The value fits when every bit above the OUT_W sign bit matches it.
    logic [IN_W-OUT_W:0] upper;
    assign upper = value[IN_W-1:OUT_W-1];

    always_comb begin
        clamped = value[OUT_W-1:0];
        if (!(upper == '0 || upper == '1)) begin
            if (value[IN_W-1]) begin
                clamped = {1'b1, {(OUT_W-1){1'b0}}};
            end else begin
                clamped = {1'b0, {(OUT_W-1){1'b1}}};
            end
        end
    end

endmodule

// File: rtl/conv_mac_accumulator.sv
// Streaming multiply-accumulate over TAP_COUNT (pixel, weight) pairs plus bias,
// saturated to ACC_W and presented on a valid/ready port feeding the ReLU stage.
module conv_mac_accumulator
    import sr_fixed_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int WEIGHT_W  = WEIGHT_W_DEF,
    parameter int ACC_W     = ACC_W_DEF,
    parameter int TAP_COUNT = 9,
    parameter int GUARD_W   = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic signed [DATA_W-1:0]   in_data,
    input  logic signed [WEIGHT_W-1:0] in_weight,
    input  logic signed [ACC_W-1:0]    in_bias,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic signed [ACC_W-1:0]    out_data,
    output logic                       busy
);

    localparam int P_W   = DATA_W + WEIGHT_W;
    localparam int INT_W = ACC_W + GUARD_W;

    mac_state_t state, state_next;

    logic [7:0]              tap_cnt;
    logic signed [P_W-1:0]   prod_p1;
    logic                    vld_p1;
    logic signed [INT_W-1:0] acc_p2;
    logic signed [ACC_W-1:0] acc_sat;
    logic                    take_in;
    logic                    take_out;
    logic                    last_tap;

    assign in_ready = (state == ST_ACCUM);
    assign take_in  = in_valid && in_ready;
    assign take_out = out_valid && out_ready;
    assign last_tap = (tap_cnt == 8'(TAP_COUNT - 1));
    assign busy     = (tap_cnt != 8'd0) || (state != ST_ACCUM) || vld_p1;

    always_comb begin
        state_next = state;
        case (state)
            ST_ACCUM: if (take_in && last_tap) state_next = ST_DRAIN;
            ST_DRAIN: if (!vld_p1) state_next = ST_HOLD;
            ST_HOLD:  if (take_out) state_next = ST_ACCUM;
            default:  state_next = ST_ACCUM;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_ACCUM;
            tap_cnt <= 8'd0;
        end else begin
            state <= state_next;
            if (take_in) begin
                tap_cnt <= last_tap ? 8'd0 : tap_cnt + 8'd1;
            end
        end
    end

    // Stage p1: full-precision product of the accepted pair
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_p1 <= '0;
            vld_p1  <= 1'b0;
        end else begin
            vld_p1 <= take_in;
            if (take_in) begin
                prod_p1 <= P_W'(in_data) * P_W'(in_weight);
            end
        end
    end

    // Stage p2: guarded accumulator; a window's first tap reloads it with the bias
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_p2 <= '0;
        end else if (take_in && tap_cnt == 8'd0) begin
            acc_p2 <= INT_W'(in_bias);
        end else if (vld_p1) begin
            acc_p2 <= acc_p2 + INT_W'(prod_p1);
        end else if (take_out) begin
            acc_p2 <= '0;
        end
    end

    sat_clamp #(
        .IN_W  (INT_W),
        .OUT_W (ACC_W)
    ) u_sat_clamp (
        .value   (acc_p2),
        .clamped (acc_sat)
    );

    // Output register: loaded once the last product has landed in the accumulator
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data  <= '0;
            out_valid <= 1'b0;
        end else if (state == ST_DRAIN && !vld_p1) begin
            out_data  <= acc_sat;
            out_valid <= 1'b1;
        end else if (state == ST_HOLD && take_out) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_conv_mac_accumulator.sv
// Randomized bench for conv_mac_accumulator: each window is compared against a
// plain-arithmetic model (bias + sum of products, clamped to 32-bit signed).
module tb_conv_mac_accumulator;
    import sr_fixed_pkg::*;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic signed [15:0] in_data = '0;
    logic signed [15:0] in_weight = '0;
    logic signed [31:0] in_bias = '0;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic signed [31:0] out_data;
    logic               busy;

    int errors = 0;
    int checks = 0;

    logic signed [15:0] td [9];
    logic signed [15:0] tw [9];

    conv_mac_accumulator dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_weight (in_weight),
        .in_bias   (in_bias),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic signed [31:0] model(input logic signed [31:0] b);
        longint s;
        logic signed [31:0] r;
        s = longint'(b);
        for (int i = 0; i < 9; i++) s += longint'(td[i]) * longint'(tw[i]);
        if (s > 64'sd2147483647) return SAT_MAX;
        if (s < -64'sd2147483648) return SAT_MIN;
        r = s[31:0];
        return r;
    endfunction

    task automatic fill(input logic signed [15:0] d, input logic signed [15:0] w);
        for (int i = 0; i < 9; i++) begin
            td[i] = d;
            tw[i] = w;
        end
    endtask

    // Drives one window from td/tw and waits (bounded) for the result.
    task automatic send_window(input logic signed [31:0] b, input int bub_pct, input bit scramble,
                               output int lat, output logic signed [31:0] res);
        for (int i = 0; i < 9; i++) begin
            while (int'($urandom_range(99)) < bub_pct) begin
                in_valid  = 1'b0;
                in_data   = 16'($urandom);
                in_weight = 16'($urandom);
                in_bias   = 32'($urandom);
                @(negedge clk);
            end
            in_valid  = 1'b1;
            in_data   = td[i];
            in_weight = tw[i];
            in_bias   = (i == 0 || !scramble) ? b : 32'($urandom);
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_bias  = 32'($urandom);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        res = out_data;
    endtask

    task automatic handoff();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (out_data !== 32'sd0) begin errors++; $display("FAIL reset_out_data: got %0d expected 0", out_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    endtask

    task automatic test_ones();
        int lat;
        logic signed [31:0] res;
        fill(16'sd1, 16'sd1);
        send_window(32'sd0, 0, 1'b0, lat, res);
        checks++; if (res !== 32'sd9) begin errors++; $display("FAIL ones_data: got %0d expected 9", res); end
        checks++; if (lat != 2) begin errors++; $display("FAIL ones_latency: got %0d expected 2", lat); end
        checks++; if (busy !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL ones_hold_flags: busy=%b in_ready=%b expected 1/0", busy, in_ready); end
        handoff();
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL ones_after_handoff: out_valid=%b in_ready=%b busy=%b expected 0/1/0", out_valid, in_ready, busy);
        end
    endtask

    task automatic test_negative();
        int lat;
        logic signed [31:0] res;
        fill(-16'sd100, 16'sd300);
        send_window(32'sd0, 0, 1'b0, lat, res);
        checks++; if (res !== -32'sd270000) begin errors++; $display("FAIL negative_sum: got %0d expected -270000", res); end
        handoff();
        send_window(32'sd270005, 0, 1'b0, lat, res);
        checks++; if (res !== 32'sd5) begin errors++; $display("FAIL negative_bias: got %0d expected 5", res); end
        handoff();
    endtask

    task automatic test_saturation();
        int lat;
        logic signed [31:0] res;
        fill(16'sh7FFF, 16'sh7FFF);
        send_window(32'sd0, 0, 1'b0, lat, res);
        checks++; if (res !== 32'sh7FFFFFFF) begin errors++; $display("FAIL sat_pos: got %h expected 7fffffff", res); end
        handoff();
        fill(-16'sd32768, 16'sd32767);
        send_window(32'sd0, 0, 1'b0, lat, res);
        checks++; if (res !== 32'sh80000000) begin errors++; $display("FAIL sat_neg: got %h expected 80000000", res); end
        handoff();
    endtask

    task automatic test_backpressure();
        int lat;
        logic signed [31:0] res;
        logic signed [31:0] exp;
        fill(16'sd2, 16'sd3);
        exp = model(32'sd1);
        send_window(32'sd1, 0, 1'b0, lat, res);
        checks++; if (res !== exp) begin errors++; $display("FAIL bp_first: got %0d expected %0d", res, exp); end
        for (int k = 0; k < 5; k++) begin
            in_valid  = 1'b1;
            in_data   = 16'($urandom);
            in_weight = 16'($urandom);
            @(negedge clk);
            checks++; if (out_valid !== 1'b1 || out_data !== exp || in_ready !== 1'b0) begin
                errors++; $display("FAIL bp_hold: cycle %0d out_valid=%b out_data=%0d in_ready=%b expected 1/%0d/0", k, out_valid, out_data, in_ready, exp);
            end
        end
        in_valid = 1'b0;
        handoff();
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL bp_release: in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid); end
        fill(16'sd1, 16'sd1);
        send_window(32'sd0, 0, 1'b0, lat, res);
        checks++; if (res !== 32'sd9) begin errors++; $display("FAIL bp_next_window: got %0d expected 9", res); end
        handoff();
    endtask

    task automatic test_bubbles();
        int lat;
        logic signed [31:0] res;
        fill(16'sd1, 16'sd1);
        send_window(32'sd0, 40, 1'b1, lat, res);
        checks++; if (res !== 32'sd9) begin errors++; $display("FAIL bubbles_ones: got %0d expected 9", res); end
        checks++; if (lat != 2) begin errors++; $display("FAIL bubbles_latency: got %0d expected 2", lat); end
        handoff();
        fill(-16'sd100, 16'sd300);
        send_window(32'sd270005, 40, 1'b1, lat, res);
        checks++; if (res !== 32'sd5) begin errors++; $display("FAIL bubbles_negative: got %0d expected 5", res); end
        handoff();
    endtask

    task automatic test_reset_mid();
        int lat;
        logic signed [31:0] res;
        fill(16'sd1, 16'sd1);
        for (int i = 0; i < 4; i++) begin
            in_valid  = 1'b1;
            in_data   = 16'sd7;
            in_weight = 16'sd5;
            in_bias   = 32'sd1000;
            @(negedge clk);
        end
        in_valid = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midreset_busy_before: got %b expected 1", busy); end
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || out_data !== 32'sd0 || busy !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL midreset_values: out_valid=%b out_data=%0d busy=%b in_ready=%b expected 0/0/0/1", out_valid, out_data, busy, in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_window(32'sd0, 0, 1'b0, lat, res);
        checks++; if (res !== 32'sd9) begin errors++; $display("FAIL midreset_fresh: got %0d expected 9", res); end
        handoff();
    endtask

    task automatic test_random();
        int lat;
        logic signed [31:0] res;
        logic signed [31:0] exp;
        logic signed [31:0] b;
        for (int n = 0; n < 10; n++) begin
            for (int i = 0; i < 9; i++) begin
                td[i] = (n % 3 == 0) ? 16'($urandom_range(32767, 30000)) : 16'($urandom);
                tw[i] = (n % 3 == 0) ? 16'($urandom_range(32767, 30000)) : 16'($urandom);
            end
            b = 32'($urandom);
            exp = model(b);
            send_window(b, 30, 1'b1, lat, res);
            checks++; if (res !== exp || lat != 2) begin
                errors++; $display("FAIL random_window%0d: got %0d lat %0d expected %0d lat 2", n, res, lat, exp);
            end
            repeat ($urandom_range(3)) @(negedge clk);
            handoff();
        end
    endtask

    initial begin
        test_reset();
        test_ones();
        test_negative();
        test_saturation();
        test_backpressure();
        test_bubbles();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
